// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encodings
package uart_pkg;

   localparam int DATAWIDTH = 8;

   // 56 gives a short bit period for simulation; 5207 is the real-baud value.
`ifdef UART_SYNTH
   localparam int BAUD_END = 5207;
`else
   localparam int BAUD_END = 56;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signals of the receiver
interface uart_rx_if #(
   parameter int DATAWIDTH = 8
);
   logic                 rs232_rx;
   logic [DATAWIDTH-1:0] rx_data;
   logic                 rx_done;
   logic                 frame_err;
   logic                 rx_busy;

   // receiver side: consumes the line, produces the byte and status pulses
   modport master (
      input  rs232_rx,
      output rx_data,
      output rx_done,
      output frame_err,
      output rx_busy
   );

   // user side: drives the line, consumes the byte and status pulses
   modport slave (
      output rs232_rx,
      input  rx_data,
      input  rx_done,
      input  frame_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer with selectable reset value
module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic d,
   output logic q
);

   logic meta;

   // two back-to-back flops; both preset so an idle-high line sees no edge out of reset
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - minimal 8N1 transmitter used as the receiver's loopback partner
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATAWIDTH      = uart_pkg::DATAWIDTH,
   parameter int BAUD_END       = uart_pkg::BAUD_END,
   parameter int BAUD_CNT_WIDTH = 32,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic [DATAWIDTH-1:0] tx_data,
   input  logic                 tx_start,
   output logic                 rs232_tx,
   output logic                 tx_busy
);

   localparam logic [BAUD_CNT_WIDTH-1:0] BAUD_LAST = BAUD_CNT_WIDTH'(BAUD_END);
   localparam logic [BIT_CNT_WIDTH-1:0]  BIT_LAST  = BIT_CNT_WIDTH'(DATAWIDTH + 1);

   // start bit in the LSB, stop bit in the MSB; shifting in ones leaves the line idle
   logic [DATAWIDTH+1:0]      frame;
   logic [BAUD_CNT_WIDTH-1:0] baud_cnt;
   logic [BIT_CNT_WIDTH-1:0]  bit_cnt;

   // load a frame on request, then shift one bit out per bit period
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         frame    <= '1;
         tx_busy  <= 1'b0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (!tx_busy) begin
         if (tx_start) begin
            frame    <= {1'b1, tx_data, 1'b0};
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
         end
      end else if (baud_cnt == BAUD_LAST) begin
         baud_cnt <= '0;
         frame    <= {1'b1, frame[DATAWIDTH+1:1]};
         if (bit_cnt == BIT_LAST) begin
            tx_busy <= 1'b0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

   assign rs232_tx = frame[0];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - mid-bit sampling UART receiver with framing-error detection
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATAWIDTH      = uart_pkg::DATAWIDTH,
   parameter int BAUD_END       = uart_pkg::BAUD_END,
   parameter int BAUD_CNT_WIDTH = 32,
   parameter int BIT_CNT_WIDTH  = 4
) (
   input  logic      CLK,
   input  logic      RSTn,
   uart_rx_if.master bus
);

   localparam logic [BAUD_CNT_WIDTH-1:0] BAUD_LAST = BAUD_CNT_WIDTH'(BAUD_END);
   localparam logic [BAUD_CNT_WIDTH-1:0] BAUD_MID  = BAUD_CNT_WIDTH'(BAUD_END / 2);
   localparam logic [BIT_CNT_WIDTH-1:0]  BIT_LAST  = BIT_CNT_WIDTH'(DATAWIDTH - 1);

   uart_state_t               state, state_next;
   logic                      rx_sync;
   logic                      rx_prev;
   logic                      fall;
   logic                      sample;
   logic [BAUD_CNT_WIDTH-1:0] baud_cnt;
   logic [BIT_CNT_WIDTH-1:0]  bit_cnt;
   logic [DATAWIDTH-1:0]      shift;
   logic [DATAWIDTH-1:0]      rx_data;
   logic                      rx_done;
   logic                      frame_err;
   logic                      rx_busy;

   uart_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .CLK  (CLK),
      .RSTn (RSTn),
      .d    (bus.rs232_rx),
      .q    (rx_sync)
   );

   // third copy of the line, compared against the synchronized sample for edge detection
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         rx_prev <= 1'b1;
      end else begin
         rx_prev <= rx_sync;
      end
   end

   assign fall   = rx_prev & ~rx_sync;
   assign sample = (baud_cnt == BAUD_MID);

   // state register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // next state: every decision is taken at the mid-bit sample point
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (fall) state_next = START;
         START:   if (sample) state_next = rx_sync ? IDLE : DATA;
         DATA:    if (sample && (bit_cnt == BIT_LAST)) state_next = STOP;
         STOP:    if (sample) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // bit-period and bit counters; both parked at zero while idle
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else if (state == IDLE) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         baud_cnt <= (baud_cnt == BAUD_LAST) ? '0 : baud_cnt + 1'b1;
         if ((state == DATA) && sample) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   // data capture, LSB first, and registered result/status outputs
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         shift     <= '0;
         rx_data   <= '0;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         rx_busy   <= 1'b0;
      end else begin
         if ((state == DATA) && sample) begin
            shift <= {rx_sync, shift[DATAWIDTH-1:1]};
         end
         if ((state == STOP) && sample && rx_sync) begin
            rx_data <= shift;
         end
         rx_done   <= (state == STOP) && sample && rx_sync;
         frame_err <= (state == STOP) && sample && !rx_sync;
         rx_busy   <= (state_next != IDLE);
      end
   end

   assign bus.rx_data   = rx_data;
   assign bus.rx_done   = rx_done;
   assign bus.frame_err = frame_err;
   assign bus.rx_busy   = rx_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with loopback through uart_tx
module tb_uart_rx;

   localparam int DW      = 8;
   localparam int BE      = 56;
   localparam int BIT_T   = BE + 1;
   localparam int LAT_EXP = 2 + 1 + (DW + 1) * BIT_T + BE / 2 + 1;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          drv_line = 1'b1;
   logic          loop = 1'b0;
   logic [DW-1:0] tx_data = '0;
   logic          tx_start = 1'b0;
   logic          tx_line;
   logic          tx_busy;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            t_fall = 0;
   bit            lat_armed = 1'b0;
   int            done_cnt = 0;
   int            ferr_cnt = 0;
   logic          prev_done = 1'b0;
   logic [DW-1:0] exp_q[$];

   uart_rx_if #(.DATAWIDTH(DW)) rx_if ();

   assign rx_if.rs232_rx = loop ? tx_line : drv_line;

   uart_rx #(
      .DATAWIDTH      (DW),
      .BAUD_END       (BE),
      .BAUD_CNT_WIDTH (32),
      .BIT_CNT_WIDTH  (4)
   ) dut (
      .CLK  (clk),
      .RSTn (rstn),
      .bus  (rx_if.master)
   );

   uart_tx #(
      .DATAWIDTH      (DW),
      .BAUD_END       (BE),
      .BAUD_CNT_WIDTH (32),
      .BIT_CNT_WIDTH  (4)
   ) u_tx (
      .CLK      (clk),
      .RSTn     (rstn),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .rs232_tx (tx_line),
      .tx_busy  (tx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // scoreboard side: every rx_done pops the oldest expected byte
   always @(negedge clk) begin
      if (rx_if.rx_done) begin
         done_cnt++;
         check("done_width", {31'd0, prev_done}, 32'd0);
         check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            check("rx_data", {24'd0, rx_if.rx_data}, {24'd0, exp_q.pop_front()});
         end
         if (lat_armed) begin
            lat_armed = 1'b0;
            check("latency", cyc - t_fall, LAT_EXP);
         end
      end
      if (rx_if.frame_err) begin
         ferr_cnt++;
         check("err_exclusive", {31'd0, rx_if.rx_done}, 32'd0);
      end
      prev_done = rx_if.rx_done;
   end

   task automatic send_frame(input logic [DW-1:0] b, input logic stop);
      drv_line = 1'b0;
      t_fall   = cyc;
      repeat (BIT_T) @(negedge clk);
      for (int i = 0; i < DW; i++) begin
         drv_line = b[i];
         repeat (BIT_T) @(negedge clk);
      end
      drv_line = stop;
      repeat (BIT_T) @(negedge clk);
      drv_line = 1'b1;
   endtask

   task automatic tx_send(input logic [DW-1:0] b);
      exp_q.push_back(b);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      for (int i = 0; i < 20 * BIT_T; i++) begin
         @(negedge clk);
         if (!tx_busy) break;
      end
      check("tx_finished", {31'd0, tx_busy}, 32'd0);
   endtask

   initial begin
      int d0, f0;

      // reset state
      #1;
      check("rst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
      check("rst_rx_done", {31'd0, rx_if.rx_done}, 32'd0);
      check("rst_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
      check("rst_rx_busy", {31'd0, rx_if.rx_busy}, 32'd0);
      repeat (4) @(negedge clk);
      rstn = 1'b1;
      repeat (4) @(negedge clk);

      // clean 0x55 with latency measurement
      exp_q.push_back(8'h55);
      lat_armed = 1'b1;
      send_frame(8'h55, 1'b1);
      repeat (10) @(negedge clk);
      check("pending_0x55", exp_q.size(), 0);
      check("ferr_0x55", ferr_cnt, 0);
      check("latency_seen", {31'd0, lat_armed}, 32'd0);

      // 10-cycle glitch on an idle line
      d0 = done_cnt;
      drv_line = 1'b0;
      repeat (10) @(negedge clk);
      drv_line = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (!rx_if.rx_busy) break;
      end
      check("glitch_idle", {31'd0, rx_if.rx_busy}, 32'd0);
      repeat (BIT_T) @(negedge clk);
      check("glitch_no_done", done_cnt, d0);
      check("glitch_no_ferr", ferr_cnt, 0);

      // 0xA3 with a bad stop bit
      f0 = ferr_cnt;
      send_frame(8'hA3, 1'b0);
      repeat (10) @(negedge clk);
      check("ferr_pulse", ferr_cnt, f0 + 1);
      check("ferr_hold_data", {24'd0, rx_if.rx_data}, 32'h55);

      // back-to-back frames with a single stop bit
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h00);
      send_frame(8'hA3, 1'b1);
      send_frame(8'h00, 1'b1);
      repeat (10) @(negedge clk);
      check("pending_b2b", exp_q.size(), 0);

      // loopback through the transmitter
      loop = 1'b1;
      tx_send(8'h00);
      tx_send(8'h5A);
      tx_send(8'hFF);
      repeat (10) @(negedge clk);
      check("pending_loop", exp_q.size(), 0);
      check("loop_last", {24'd0, rx_if.rx_data}, 32'hFF);
      loop = 1'b0;
      repeat (BIT_T) @(negedge clk);

      // reset in the middle of bit 4 of a 0xFF frame
      d0 = done_cnt;
      drv_line = 1'b0;
      repeat (BIT_T) @(negedge clk);
      drv_line = 1'b1;
      repeat (4 * BIT_T + BIT_T / 2) @(negedge clk);
      check("busy_mid_frame", {31'd0, rx_if.rx_busy}, 32'd1);
      rstn = 1'b0;
      #1;
      check("midrst_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
      check("midrst_rx_done", {31'd0, rx_if.rx_done}, 32'd0);
      check("midrst_frame_err", {31'd0, rx_if.frame_err}, 32'd0);
      check("midrst_rx_busy", {31'd0, rx_if.rx_busy}, 32'd0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      repeat (5 * BIT_T) @(negedge clk);
      check("midrst_no_done", done_cnt, d0);
      check("midrst_idle", {31'd0, rx_if.rx_busy}, 32'd0);

      // recovery on the next clean frame
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b1);
      repeat (10) @(negedge clk);
      check("pending_final", exp_q.size(), 0);
      check("total_done", done_cnt, 7);
      check("total_ferr", ferr_cnt, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // absolute time limit in case the stimulus ever stalls
   initial begin
      #2_000_000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATAWIDTH, default 8, SHALL be the data bits per frame.
REQ-002 Parameter BAUD_END, default 56, SHALL set the bit period to BAUD_END+1 CLK cycles.
REQ-003 Parameter BAUD_CNT_WIDTH, default 32, SHALL be the baud counter width.
REQ-004 Parameter BIT_CNT_WIDTH, default 4, SHALL be the bit counter width.
REQ-005 CLK  input  1  rising-edge system clock.
REQ-006 RSTn  input  1  asynchronous, active-low reset.
REQ-007 rs232_rx  input  1  asynchronous serial line; idle high.
REQ-008 rx_data  output  DATAWIDTH  last correctly framed byte, LSB first on the line.
REQ-009 rx_done  output  1  one-cycle pulse when rx_data has just been updated.
REQ-010 frame_err  output  1  one-cycle pulse when the stop bit sampled low.
REQ-011 rx_busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 rs232_rx SHALL pass through a 2-FF synchronizer, both stages reset to 1, before any use.
REQ-013 A falling edge SHALL be detected from a third registered copy: previous sample 1, current synchronized sample 0.
REQ-014 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-015 IDLE -> START SHALL occur on a detected falling edge; baud_cnt and bit_cnt are cleared.
REQ-016 Outside IDLE, baud_cnt SHALL count 0..BAUD_END and wrap to 0.
REQ-017 The sample point SHALL be baud_cnt == BAUD_END/2 (integer division).
REQ-018 START: if the line is 0 at the sample point, go to DATA; if it is 1, treat as a glitch and return to IDLE with no output pulse.
REQ-019 DATA: at each sample point, shift the line value into a shift register, LSB first, and increment bit_cnt.
REQ-020 DATA -> STOP SHALL occur at the sample point where bit_cnt reaches DATAWIDTH-1, after that bit is captured.
REQ-021 STOP with line 1 at the sample point: load rx_data from the shift register and pulse rx_done on the next cycle.
REQ-022 STOP with line 0 at the sample point: pulse frame_err on the next cycle; rx_data SHALL hold its previous value.
REQ-023 STOP -> IDLE SHALL occur at the stop sample point, not at the end of the stop bit, so back-to-back frames are accepted.
REQ-024 rx_done and frame_err SHALL never be high together and SHALL each be exactly one cycle wide.
REQ-025 Falling edges SHALL be ignored outside IDLE.
REQ-026 rx_data SHALL be stable between rx_done pulses.
REQ-027 Latency from the line falling edge to rx_done SHALL be 2 (sync) + 1 (edge) + (DATAWIDTH+1)*(BAUD_END+1) + BAUD_END/2 + 1 cycles, ±1 cycle.

Reset
REQ-028 Asserting RSTn low SHALL force, at any time including mid-frame: FSM to IDLE, counters to 0, synchronizer and edge registers to 1, rx_data to 0, and rx_done, frame_err, rx_busy to 0.
REQ-029 After release, a frame already in progress SHALL NOT produce rx_done; the next clean falling edge starts reception.

Structure
REQ-030 BAUD_END (56 in simulation, 5207 in synthesis), DATAWIDTH and the FSM state encodings SHALL live in a shared uart_pkg include used by both uart_rx and uart_tx.
REQ-031 The 2-FF synchronizer SHALL be a separate sub-module, uart_sync, with a reset-value parameter.
REQ-032 The design SHALL be a single clock domain, with no latches and no combinational outputs.

Verification (BAUD_END=56, bit period 57 cycles)
REQ-033 Send 0x55 with a valid stop bit -> exactly one rx_done, rx_data=0x55, frame_err never asserted.
REQ-034 Drive a 10-cycle low glitch on an idle line -> back in IDLE within 30 cycles, no rx_done, no frame_err.
REQ-035 Send 0xA3 with the stop bit forced 0 -> one frame_err pulse, rx_data keeps its prior value 0x55, no rx_done.
REQ-036 Send 0xA3 then 0x00 back-to-back with a 1-bit stop and no idle gap -> two rx_done pulses, rx_data 0xA3 then 0x00.
REQ-037 Assert RSTn low mid-bit 4 of a 0xFF frame -> all outputs 0 immediately; no rx_done for the remainder of that frame.
REQ-038 Loopback uart_tx.rs232_tx to uart_rx.rs232_rx and send bytes 0x00, 0x5A, 0xFF -> each received in order, each with one rx_done.
